// File: rtl/seq_divider_if.sv
// Operand/result bundle between the execute stage and the sequential divider.
// The master drives the request side, and the divider (slave) drives the results.
interface seq_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift/subtract divider that produces one quotient bit per clock.
// Signed operands are divided as magnitudes, and the signs are restored in FIX.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one trial subtraction per cycle, WIDTH cycles
// FIX   | sign fix-up / divide-by-zero override, results written
// DONE  | done pulse, start still ignored
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] dvd_orig_q;
    logic [CW-1:0]    count_q;
    logic             signed_q;
    logic             neg_dvd_q;
    logic             neg_dvs_q;
    logic             dvs_zero_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;
    logic             busy_q;
    logic             done_q;

    logic             neg_dvd_d;
    logic             neg_dvs_d;
    logic [WIDTH-1:0] dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_d;
    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;

    always_comb begin
        neg_dvd_d = bus.is_signed & bus.dividend[WIDTH-1];
        neg_dvs_d = bus.is_signed & bus.divisor[WIDTH-1];
        dvd_mag_d = neg_dvd_d ? -bus.dividend : bus.dividend;
        dvs_mag_d = neg_dvs_d ? -bus.divisor : bus.divisor;
        shifted_d = {r_q, q_q[WIDTH-1]};
        // The partial remainder stays below the divisor, so bit WIDTH of the trial result is its sign.
        trial_d   = shifted_d - {1'b0, dvsr_q};
        q_fix_d   = (signed_q && (neg_dvd_q != neg_dvs_q)) ? -q_q : q_q;
        r_fix_d   = (signed_q && neg_dvd_q) ? -r_q : r_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            r_q           <= '0;
            q_q           <= '0;
            dvsr_q        <= '0;
            dvd_orig_q    <= '0;
            count_q       <= '0;
            signed_q      <= 1'b0;
            neg_dvd_q     <= 1'b0;
            neg_dvs_q     <= 1'b0;
            dvs_zero_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        signed_q   <= bus.is_signed;
                        neg_dvd_q  <= neg_dvd_d;
                        neg_dvs_q  <= neg_dvs_d;
                        dvd_orig_q <= bus.dividend;
                        dvs_zero_q <= (bus.divisor == '0);
                        dvsr_q     <= dvs_mag_d;
                        r_q        <= '0;
                        q_q        <= dvd_mag_d;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    r_q     <= trial_d[WIDTH] ? shifted_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
                    q_q     <= {q_q[WIDTH-2:0], ~trial_d[WIDTH]};
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dvs_zero_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dvd_orig_q;
                    end else begin
                        quotient_q  <= q_fix_d;
                        remainder_q <= r_fix_d;
                    end
                    div_by_zero_q <= dvs_zero_q;
                    done_q        <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against an arithmetic reference.
module tb_seq_divider;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        dz = (b == 0);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        edz;
        int          lat;
        int          busy_cnt;
        ref_div(sgn, a, b, eq, er, edz);
        launch(sgn, a, b);
        lat      = 0;
        busy_cnt = 0;
        if (bus.busy) busy_cnt++;
        while (!bus.done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_cnt++;
        end
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_quot"}, bus.quotient, eq);
        chk({tag, "_rem"}, bus.remainder, er);
        chk({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, edz});
        @(posedge clk);
        #1;
        chk({tag, "_busy_cycles"}, busy_cnt, 34);
        chk({tag, "_idle"}, {30'b0, bus.busy, bus.done}, 32'b0);
    endtask

    initial begin
        logic [31:0] a, b;
        int          lat;
        int          ndone;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quot", bus.quotient, 0);
        chk("rst_rem", bus.remainder, 0);
        chk("rst_flags", {29'b0, bus.busy, bus.done, bus.div_by_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("u100_7", 1'b0, 32'd100, 32'd7);
        do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_op("u5_0", 1'b0, 32'd5, 32'd0);
        do_op("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("u_ovf_pat", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Stray starts during RUN and during the DONE cycle must be ignored.
        launch(1'b0, 32'd1000, 32'd3);
        lat = 0;
        while (!bus.done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b1;
                bus.dividend  = 32'd77;
                bus.divisor   = 32'd5;
            end else if (lat == 6) begin
                bus.start = 1'b0;
            end
        end
        chk("ign_latency", lat, 33);
        bus.start     = 1'b1;
        bus.dividend  = 32'd50;
        bus.divisor   = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign_done_busy", {31'b0, bus.busy}, 0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("ign_extra_done", ndone, 0);
        chk("ign_quot", bus.quotient, 333);
        chk("ign_rem", bus.remainder, 1);

        // Reset at the 10th RUN edge aborts the operation.
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_quot", bus.quotient, 0);
        chk("abort_rem", bus.remainder, 0);
        chk("abort_flags", {29'b0, bus.busy, bus.done, bus.div_by_zero}, 0);
        do_op("after_abort", 1'b0, 32'd100, 32'd7);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            do_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
